// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker pair.
// Holds the checker FSM encoding, the LFSR recurrence used by both ends of
// the link, and a popcount helper used for bit-error accounting.
package prbs_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Widest LFSR the helpers support; callers zero-extend into this width
  // and cast the result back down to their own N.
  localparam int MAX_W = 64;

  // next(s) = {s[n-2:0], s[n-1] ^ s[n-2]} for an n-bit register held in the
  // low bits of s. Written with shifts so n can be a run-time argument.
  function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] s,
                                                 input int               n);
    logic [MAX_W-1:0] fb;
    logic [MAX_W-1:0] mask;
    fb   = ((s >> (n - 1)) ^ (s >> (n - 2))) & MAX_W'(1);
    mask = (MAX_W'(1) << n) - MAX_W'(1);
    return ((s << 1) | fb) & mask;
  endfunction

  function automatic logic [7:0] popcount(input logic [MAX_W-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < MAX_W; i++) begin
      c = c + {7'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/prbs_err_counter.sv
// Saturating error accumulator with synchronous clear.
// Ports: clk, reset (async, active-high), clear (wins over inc_en),
//        inc_en/inc (add inc this cycle), cnt (clamps at all-ones, never wraps).
module prbs_err_counter #(
  parameter int CNT_W = 16,
  parameter int INC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc_en,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] cnt
);

  // One extra bit over the wider operand so the sum itself never overflows
  // and the clamp decision is a plain compare.
  localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [SUM_W-1:0] sum;
  assign sum = SUM_W'(cnt) + SUM_W'(inc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc_en) begin
      cnt <= (sum > CNT_MAX) ? {CNT_W{1'b1}} : CNT_W'(sum);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS stream checker: hunts for a nonzero seed, verifies LOCK_CNT predicted
// words, then free-runs its own LFSR and counts word/bit errors.
// Ports: clk, reset (async, active-high), in_valid/in_data (word stream),
//        clear (zero the counters), locked, err_pulse, err_word_cnt,
//        err_bit_cnt, state (HUNT=0, VERIFY=1, LOCKED=2). Outputs registered.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int N          = 4,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_word_cnt,
  output logic [CNT_W-1:0] err_bit_cnt,
  output logic [1:0]       state
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  state_t          state_q;
  logic [N-1:0]    pred;
  logic [N-1:0]    exp_word;
  logic [MW-1:0]   match_cnt;
  logic [UW-1:0]   miss_cnt;
  logic            word_match;
  logic            word_err;
  logic [7:0]      bit_errs;

  assign exp_word   = N'(lfsr_next(MAX_W'(pred), N));
  assign word_match = (in_data == exp_word);
  // Errors are only accounted while locked; during HUNT/VERIFY a mismatch
  // just means we have not found the stream yet.
  assign word_err   = in_valid && (state_q == LOCKED) && !word_match;
  assign bit_errs   = popcount(MAX_W'(in_data ^ exp_word));
  assign state      = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= HUNT;
      pred      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        case (state_q)
          HUNT: begin
            // An all-zero word is the LFSR lock-up state and can never be
            // part of a valid sequence, so it is not accepted as a seed.
            if (in_data != '0) begin
              pred      <= in_data;
              match_cnt <= '0;
              state_q   <= VERIFY;
            end
          end
          VERIFY: begin
            if (word_match) begin
              pred <= in_data;
              if (match_cnt == MW'(LOCK_CNT - 1)) begin
                match_cnt <= '0;
                miss_cnt  <= '0;
                locked    <= 1'b1;
                state_q   <= LOCKED;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              state_q <= HUNT;
            end
          end
          LOCKED: begin
            // Free-running: the received word never reseeds the predictor,
            // so a single corrupted word costs exactly one error.
            pred <= exp_word;
            if (word_match) begin
              miss_cnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (miss_cnt == UW'(UNLOCK_CNT - 1)) begin
                miss_cnt <= '0;
                locked   <= 1'b0;
                state_q  <= HUNT;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end
          end
          default: begin
            state_q <= HUNT;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

  prbs_err_counter #(
    .CNT_W (CNT_W),
    .INC_W (1)
  ) u_word_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .inc_en (word_err),
    .inc    (1'b1),
    .cnt    (err_word_cnt)
  );

  prbs_err_counter #(
    .CNT_W (CNT_W),
    .INC_W (8)
  ) u_bit_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .inc_en (word_err),
    .inc    (bit_errs),
    .cnt    (err_bit_cnt)
  );

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Consumes the parallel N-bit pseudo-random word stream from the upstream LFSR generator, one word per valid cycle. Predicts each next word with the same feedback function.
- Synchronises to the stream, reports lock status, and counts word and bit errors for link/BIST checking.
- Sits directly downstream of the generator, or at the far end of the link the generator drives.

Parameters:
N, 4, LFSR width; must be >= 3.
LOCK_CNT, 4, consecutive correct predictions needed to declare lock (>= 1).
UNLOCK_CNT, 3, consecutive word errors in LOCKED that force a return to HUNT (>= 1).
CNT_W, 16, width of the saturating error counters.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  in_data carries a new LFSR word this cycle
in_data  in  N  received LFSR word
clear  in  1  synchronous clear of both error counters
locked  out  1  checker is in LOCKED
err_pulse  out  1  one-cycle flag: last accepted word mismatched while LOCKED
err_word_cnt  out  CNT_W  saturating count of mismatched words while LOCKED
err_bit_cnt  out  CNT_W  saturating count of mismatched bits while LOCKED
state  out  2  FSM state: HUNT=0, VERIFY=1, LOCKED=2

Behaviour:
- Reset is asynchronous, active-high, clock is clk. While reset is high: state=HUNT, predictor=0, match/miss counters=0, and all outputs 0.
- next(s) = {s[N-2:0], s[N-1]^s[N-2]}. This is the same recurrence as the generator.
- exp = next(pred). pred is the registered copy of the last accepted word in HUNT/VERIFY, or the locally advanced word in LOCKED.
- Only cycles with in_valid=1 are processed. With in_valid=0, all state holds and err_pulse=0.
- HUNT:
  - A nonzero in_data seeds pred <= in_data, match_cnt <= 0, and the FSM moves to VERIFY.
  - All-zero in_data is rejected; the FSM stays in HUNT.
- VERIFY:
  - in_data==exp: pred <= in_data, match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCKED with miss_cnt <= 0.
  - in_data!=exp: go to HUNT. This word is not reused as a seed.
- LOCKED:
  - pred <= exp on every valid cycle (free-running; no resync from in_data).
  - On a match, miss_cnt <= 0.
  - On a mismatch, err_pulse=1 and miss_cnt++. err_word_cnt += 1 and err_bit_cnt += popcount(in_data ^ exp), both saturating at 2^CNT_W-1.
  - When miss_cnt reaches UNLOCK_CNT, go to HUNT. The error on that word is still counted.
- Latency: all outputs are registered and reflect the valid input one cycle after it is sampled. locked rises on the cycle after the LOCK_CNT-th matching word.
- clear=1 takes priority over any error in the same cycle: both counters load 0 and that cycle's error is dropped from the counts, but err_pulse still fires. clear does not affect the FSM.
- Counters hold their values across loss of lock. They reset only on reset or clear.
- Bit-count saturation: if the sum overflows, the result is clamped to all-ones, never wrapped.
- Reset asserted mid-operation takes effect immediately (asynchronous). Re-acquisition after release needs 1 + LOCK_CNT valid words.

Decomposition:
- Package prbs_pkg holds:
  - state encoding constants HUNT/VERIFY/LOCKED;
  - function lfsr_next(s), shared with the generator so both ends are guaranteed identical;
  - function popcount.
- One natural sub-module: prbs_err_counter, a CNT_W saturating accumulator with clear and an increment input. It is instantiated twice (word count and bit count).

Test Plan:
- Clean lock: N=4, reset, then stream 1000,0001,0010,0100,1001,0011,... with in_valid=1 -> state 0→1 after 1000; locked=1 after the 5th word (0100+1=1001 is the 4th match); counters stay 0 over 100 words.
- Single bit error: locked; send 0111 in place of expected 1111, then resume the correct sequence -> err_pulse for one cycle, err_word_cnt=1, err_bit_cnt=1, locked stays 1; subsequent correct words produce no further errors (free-running pred).
- Loss of lock: locked; send 3 consecutive wrong words (each with 2 bits flipped) -> err_word_cnt=3, err_bit_cnt=6, state returns to HUNT on the 3rd error; relock after 5 further good words.
- Zero word and valid gaps: in HUNT send 0000 -> stays HUNT; insert in_valid=0 bubbles mid-VERIFY and mid-LOCKED -> no state change and no false errors.
- Clear and saturation: CNT_W=4, force 20 errors -> err_word_cnt=15 held; assert clear together with an error -> counters 0, err_pulse=1.
- Async reset while LOCKED -> locked, state and err_pulse go to 0 without waiting for a clock edge; counters go to 0.
